// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR sequencer and the ALU it drives.
package fir_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;

    localparam int DEF_DW = 16;
    localparam int DEF_AW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } fir_state_e;

endpackage

// File: rtl/alu.sv
// Shared 16x16 ALU: add or signed multiply, result delayed by LAT register stages.
module alu
    import fir_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int AW  = DEF_AW,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [1:0]    op_sel,
    output logic [AW-1:0] result
);

    logic [AW-1:0] a_ext;
    logic [AW-1:0] b_ext;
    logic [AW-1:0] res_c;
    logic [AW-1:0] pipe [LAT];

    assign a_ext = AW'($signed(a));
    assign b_ext = AW'($signed(b));

    always_comb begin
        res_c = '0;
        case (op_sel)
            OP_MUL:  res_c = a_ext * b_ext;
            OP_ADD:  res_c = a_ext + b_ext;
            default: res_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= res_c;
            for (int i = 1; i < LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign result = pipe[LAT-1];

endmodule

// File: rtl/fir_sample_ring.sv
// Circular delay line of NTAPS samples; read port addresses the sample k steps behind wp.
module fir_sample_ring
    import fir_pkg::*;
#(
    parameter int NTAPS = 64,
    parameter int DW    = DEF_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic                     advance,
    input  logic [DW-1:0]            wr_data,
    input  logic [$clog2(NTAPS)-1:0] k,
    output logic [DW-1:0]            rd_data
);

    localparam int KW = $clog2(NTAPS);

    logic [DW-1:0] mem [NTAPS];
    logic [KW-1:0] wp;
    logic [KW-1:0] rd_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wp] <= wr_data;
        end
    end

    // Power-of-two depth makes the natural KW-bit wrap the modulo.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
        end else if (advance) begin
            wp <= wp + KW'(1);
        end
    end

    assign rd_idx  = wp - k;
    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fir_sequencer.sv
// Sequences one FIR output per input sample through the shared ALU, one tap per cycle.
//   state | meaning
//   IDLE  | waiting for a sample; coefficient writes accepted
//   RUN   | issuing tap k to the ALU each cycle
//   DRAIN | waiting for in-flight products to be accumulated
//   OUT   | holding y[n] until the consumer takes it
module fir_sequencer
    import fir_pkg::*;
#(
    parameter int NTAPS   = 64,
    parameter int DW      = DEF_DW,
    parameter int AW      = DEF_AW,
    parameter int ALU_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [DW-1:0]            coef_data,
    input  logic                     in_valid,
    input  logic [DW-1:0]            in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [AW-1:0]            out_data,
    input  logic                     out_ready,
    output logic [DW-1:0]            alu_a,
    output logic [DW-1:0]            alu_b,
    output logic [1:0]               alu_op_sel,
    input  logic [AW-1:0]            alu_result,
    output logic                     busy
);

    localparam int KW = $clog2(NTAPS);

    fir_state_e state_q;
    fir_state_e state_d;

    logic [KW-1:0]      k_q;
    logic [DW-1:0]      coef [NTAPS];
    logic [AW-1:0]      acc_q;
    logic [ALU_LAT-1:0] tag_q;
    logic [ALU_LAT-1:0] tag_rest;
    logic [DW-1:0]      tap_sample;

    logic          sample_fire;
    logic          prod_valid;
    logic          last_prod;
    logic          ring_we;
    logic          ring_adv;
    logic          coef_wr;
    logic [DW-1:0] alu_a_d;
    logic [DW-1:0] alu_b_d;
    logic [1:0]    alu_op_d;

    fir_sample_ring #(
        .NTAPS (NTAPS),
        .DW    (DW)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .we      (ring_we),
        .advance (ring_adv),
        .wr_data (in_data),
        .k       (k_q),
        .rd_data (tap_sample)
    );

    // The final product is the one with no other issue still in the ALU pipe.
    always_comb begin
        tag_rest            = tag_q;
        tag_rest[ALU_LAT-1] = 1'b0;
    end

    assign prod_valid = tag_q[ALU_LAT-1] && ((state_q == RUN) || (state_q == DRAIN));
    assign last_prod  = prod_valid && !(|tag_rest) && (alu_op_sel != OP_MUL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (k_q == KW'(NTAPS - 1)) state_d = DRAIN;
            DRAIN:   if (last_prod) state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (state_q == IDLE);
        busy        = (state_q != IDLE);
        sample_fire = (state_q == IDLE) && in_valid;
        ring_we     = sample_fire;
        coef_wr     = (state_q == IDLE) && coef_we;
        ring_adv    = (state_q == OUT) && out_ready;
        alu_a_d     = '0;
        alu_b_d     = '0;
        alu_op_d    = OP_ADD;
        if (state_q == RUN) begin
            alu_a_d  = tap_sample;
            alu_b_d  = coef[k_q];
            alu_op_d = OP_MUL;
        end
    end

    // A coefficient written alongside a sample lands before the first tap reads it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                coef[i] <= '0;
            end
        end else if (coef_wr) begin
            coef[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op_sel <= OP_ADD;
            tag_q      <= '0;
        end else begin
            alu_a      <= alu_a_d;
            alu_b      <= alu_b_d;
            alu_op_sel <= alu_op_d;
            tag_q[0]   <= (alu_op_sel == OP_MUL);
            for (int i = 1; i < ALU_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q   <= '0;
            acc_q <= '0;
        end else if (sample_fire) begin
            k_q   <= '0;
            acc_q <= '0;
        end else begin
            if (state_q == RUN) begin
                k_q <= k_q + KW'(1);
            end
            if (prod_valid) begin
                acc_q <= acc_q + alu_result;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if ((state_q == DRAIN) && last_prod) begin
            out_valid <= 1'b1;
            out_data  <= acc_q + alu_result;
        end else if ((state_q == OUT) && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/fir_sequencer.md
# fir_sequencer

Controller that runs the shared 16x16 ALU to compute one FIR output per input sample. It holds the coefficient bank and a circular sample delay line, issues one multiply per cycle to the ALU, and accumulates the returning products locally. It sits between the sample stream and the `alu` block, and presents the 32-bit filter output with a valid/ready handshake.

## Interface
- `NTAPS`, 64, number of taps (power of two, ≥ 2)
- `DW`, 16, sample/coefficient width (signed two's complement)
- `AW`, 32, product/accumulator/output width (signed)
- `ALU_LAT`, 2, cycles from operands driven on `alu_a`/`alu_b` to the matching product on `alu_result`

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `coef_we`  in  1  coefficient write strobe
- `coef_addr`  in  log2(NTAPS)  coefficient index k
- `coef_data`  in  DW  coefficient h[k]
- `in_valid`  in  1  sample offered
- `in_data`  in  DW  sample x[n]
- `in_ready`  out  1  sample accepted when `in_valid && in_ready`
- `out_valid`  out  1  filter output y[n] available
- `out_data`  out  AW  y[n] = Σ h[k]·x[n−k]
- `out_ready`  in  1  consumer accepts output
- `alu_a`  out  DW  ALU operand a (sample)
- `alu_b`  out  DW  ALU operand b (coefficient)
- `alu_op_sel`  out  2  ALU op: 2'b01 multiply while issuing, 2'b00 otherwise
- `alu_result`  in  AW  ALU result
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states are IDLE, RUN, DRAIN and OUT.
- IDLE:
  - `in_ready`=1.
  - On a sample handshake, write `in_data` to `ring[wp]`, clear `acc`, set the tap counter `k`=0, and go to RUN.
- RUN:
  - Each cycle, drive `alu_a`=`ring[(wp−k) mod NTAPS]`, `alu_b`=`h[k]`, `alu_op_sel`=2'b01, and increment `k`.
  - After issuing `k`=NTAPS−1, go to DRAIN.
- Valid shift register, depth `ALU_LAT`:
  - Tags each issue.
  - When a tagged product returns, `acc <= acc + alu_result`. Addition is AW-bit and wraps modulo 2^AW, with no saturation.
- DRAIN:
  - Waits until the last product has been accumulated, then loads `out_data <= acc + final product`.
  - Goes to OUT.
- OUT:
  - `out_valid`=1, and `out_data` is held stable.
  - On `out_ready`, clear `out_valid`, set `wp <= wp+1` (wraps at NTAPS), and go to IDLE.
- Outside RUN: `alu_a`=0, `alu_b`=0, `alu_op_sel`=2'b00, and `alu_result` is ignored.
- Coefficient writes:
  - Honoured only in IDLE. Writes in any other state are dropped silently.
  - When `coef_we` and a sample handshake occur in the same IDLE cycle, the write lands first, and the new coefficient is used for that sample.
- Delay line:
  - Never-written taps read as 0.
  - The ring wraps after NTAPS samples, with the oldest sample overwritten.

## Timing
- Reset values (asserted asynchronously):
  - FSM=IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `busy`=0.
  - `alu_a`=0, `alu_b`=0, `alu_op_sel`=2'b00.
  - `acc`=0, `wp`=0, `k`=0, valid tags=0.
  - All ring entries and all coefficients = 0.
- Latency:
  - Sample accepted at edge E0.
  - Taps are issued in cycles E0+1 … E0+NTAPS.
  - `out_valid` rises at edge E0+NTAPS+ALU_LAT+1 (67 cycles with defaults).
- Throughput:
  - `in_ready` is low from E0+1 until the cycle after the output handshake.
  - Minimum sample period is NTAPS+ALU_LAT+2 cycles.
- `out_ready` held low: stay in OUT indefinitely with `out_data` unchanged, and accept no samples.
- `rst` asserted mid-RUN/DRAIN/OUT:
  - The computation is aborted and no `out_valid` is produced.
  - The ring and coefficients are cleared.
  - The state after deassertion is identical to power-up.
- All outputs except `in_ready` and `busy` are registered. `in_ready` and `busy` are decoded from the state register only.

## Structure
- Package `fir_pkg` holds:
  - Constants OP_ADD=2'b00 and OP_MUL=2'b01.
  - Default widths DW=16 and AW=32.
  - The state enum {IDLE, RUN, DRAIN, OUT}.
- Sub-module `fir_sample_ring`:
  - NTAPS×DW register array with write pointer `wp`, a tap-offset read port (`wp−k` mod NTAPS), and async clear.
- The coefficient bank, FSM, tag pipe and accumulator stay in `fir_sequencer`.
- The bench instantiates `fir_sequencer` together with the real `alu`.

## Test plan
- Impulse response: h[k]=k+1 for all k; input 1 followed by 63 zeros → outputs 1, 2, 3, …, 64, in order.
- Latency: one sample with `out_ready`=1 → `out_valid` first high exactly 67 cycles after the input handshake, high for 1 cycle; `in_ready` high again the following cycle.
- Wrap-around overflow: all h=−32768, 64 samples of −32768:
  - 2nd output = −2147483648.
  - 4th output = 0.
  - 64th output = 0.
- Backpressure and dropped writes: `out_ready`=0 for 20 cycles in OUT → `out_data` constant and `in_ready`=0. A `coef_write(addr=0, data=5)` issued during RUN → h[0] unchanged, as shown by the next impulse output.
- Simultaneous coef write and sample in IDLE: write h[0]=7 in the same cycle as sample 3, all other h=0 and ring empty → output 21.
- Reset mid-RUN: assert `rst` at tap 10, release → no `out_valid`, `in_ready`=1, and the next impulse with h[0]=1 yields output 1 (earlier samples and coefficients cleared).
